// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII transmit framer and its CRC helper.
package gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SFD   = 3'd2,
        ST_DATA  = 3'd3,
        ST_PAD   = 3'd4,
        ST_FCS   = 3'd5,
        ST_DRAIN = 3'd6,
        ST_IFG   = 3'd7
    } gmii_state_t;

    localparam logic [7:0]  GMII_PREAMBLE   = 8'h55;
    localparam logic [7:0]  GMII_SFD        = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [2:0]  GMII_PRE_LEN    = 3'd7;

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Byte-stream input handshake and GMII output bundle of the transmit framer.
interface gmii_tx_framer_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_err;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_er;
    logic       busy;
    logic       underrun;

    modport master (
        output in_data, in_valid, in_last, in_err,
        input  in_ready, tx_data, tx_en, tx_er, busy, underrun
    );

    modport slave (
        input  in_data, in_valid, in_last, in_err,
        output in_ready, tx_data, tx_en, tx_er, busy, underrun
    );

endinterface

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 step (reflected polynomial); the register lives in the caller.
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = {1'b0, c[31:1]} ^ (c[0] ? CRC32_POLY_REFL : 32'h00000000);
        end
        return c;
    endfunction

    assign crc_out = crc32_byte(crc_in, data);

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, optional pad + FCS, inter-frame gap.
// Padding and FCS generation are built only when GMII_TX_FCS_EN is defined.
module gmii_tx_framer
    import gmii_pkg::*;
#(
    parameter int IFG_CYCLES  = 12,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic            tx_clk,
    input  logic            tx_rst,
    gmii_tx_framer_if.slave bus
);

    localparam int                IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0]  IFG_LAST = IFG_W'(IFG_CYCLES - 1);

    gmii_state_t      state_r, state_nx_s;
    logic [2:0]       pre_cnt_r, pre_cnt_nx_s;
    logic [IFG_W-1:0] ifg_cnt_r, ifg_cnt_nx_s;
    logic [7:0]       tx_data_r, tx_data_nx_s;
    logic             tx_en_r, tx_en_nx_s;
    logic             tx_er_r, tx_er_nx_s;
    logic             busy_r;
    logic             underrun_r, underrun_nx_s;

`ifdef GMII_TX_FCS_EN
    localparam logic [10:0] MIN_LEN = 11'(MIN_PAYLOAD);

    logic [10:0] byte_cnt_r, byte_cnt_nx_s, byte_cnt_inc_s;
    logic [31:0] crc_r, crc_nx_s, crc_step_s, fcs_s;
    logic [7:0]  crc_byte_s, fcs_byte_s;
    logic [1:0]  fcs_idx_r, fcs_idx_nx_s;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_r),
        .data    (crc_byte_s),
        .crc_out (crc_step_s)
    );

    // Counter saturates so oversize frames still go out in full.
    assign byte_cnt_inc_s = (byte_cnt_r == 11'h7FF) ? byte_cnt_r : byte_cnt_r + 11'd1;
    assign crc_byte_s     = (state_r == ST_PAD) ? 8'h00 : bus.in_data;
    assign fcs_s          = ~crc_r;

    // FCS byte selection, least-significant byte first.
    always_comb begin
        case (fcs_idx_r)
            2'd0:    fcs_byte_s = fcs_s[7:0];
            2'd1:    fcs_byte_s = fcs_s[15:8];
            2'd2:    fcs_byte_s = fcs_s[23:16];
            2'd3:    fcs_byte_s = fcs_s[31:24];
            default: fcs_byte_s = 8'h00;
        endcase
    end
`endif

    // Next-state and next-output logic; outputs are registered one cycle later.
    always_comb begin
        state_nx_s    = state_r;
        pre_cnt_nx_s  = pre_cnt_r;
        ifg_cnt_nx_s  = ifg_cnt_r;
        tx_data_nx_s  = 8'h00;
        tx_en_nx_s    = 1'b0;
        tx_er_nx_s    = 1'b0;
        underrun_nx_s = 1'b0;
`ifdef GMII_TX_FCS_EN
        byte_cnt_nx_s = byte_cnt_r;
        crc_nx_s      = crc_r;
        fcs_idx_nx_s  = fcs_idx_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nx_s   = ST_PRE;
                    tx_data_nx_s = GMII_PREAMBLE;
                    tx_en_nx_s   = 1'b1;
                    pre_cnt_nx_s = 3'd1;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_PRE: begin
                tx_data_nx_s = GMII_PREAMBLE;
                tx_en_nx_s   = 1'b1;
                if (pre_cnt_r == GMII_PRE_LEN - 3'd1) begin
                    state_nx_s   = ST_SFD;
                    pre_cnt_nx_s = 3'd0;
                end else begin
                    pre_cnt_nx_s = pre_cnt_r + 3'd1;
                end
            end
            ST_SFD: begin
                tx_data_nx_s  = GMII_SFD;
                tx_en_nx_s    = 1'b1;
                state_nx_s    = ST_DATA;
`ifdef GMII_TX_FCS_EN
                byte_cnt_nx_s = 11'd0;
                crc_nx_s      = CRC32_INIT;
                fcs_idx_nx_s  = 2'd0;
`endif
            end
            ST_DATA: begin
                if (bus.in_valid) begin
                    tx_data_nx_s  = bus.in_data;
                    tx_en_nx_s    = 1'b1;
                    tx_er_nx_s    = bus.in_err;
`ifdef GMII_TX_FCS_EN
                    byte_cnt_nx_s = byte_cnt_inc_s;
                    crc_nx_s      = crc_step_s;
`endif
                    if (bus.in_last) begin
`ifdef GMII_TX_FCS_EN
                        state_nx_s = (byte_cnt_inc_s < MIN_LEN) ? ST_PAD : ST_FCS;
`else
                        state_nx_s = ST_IFG;
`endif
                        ifg_cnt_nx_s = {IFG_W{1'b0}};
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else begin
                    // Underrun: one errored byte closes the frame, then discard the rest.
                    tx_en_nx_s    = 1'b1;
                    tx_er_nx_s    = 1'b1;
                    underrun_nx_s = 1'b1;
                    state_nx_s    = ST_DRAIN;
                end
            end
`ifdef GMII_TX_FCS_EN
            ST_PAD: begin
                tx_en_nx_s    = 1'b1;
                byte_cnt_nx_s = byte_cnt_inc_s;
                crc_nx_s      = crc_step_s;
                if (byte_cnt_inc_s >= MIN_LEN) begin
                    state_nx_s = ST_FCS;
                end else begin
                    state_nx_s = ST_PAD;
                end
            end
            ST_FCS: begin
                tx_data_nx_s = fcs_byte_s;
                tx_en_nx_s   = 1'b1;
                if (fcs_idx_r == 2'd3) begin
                    state_nx_s   = ST_IFG;
                    ifg_cnt_nx_s = {IFG_W{1'b0}};
                    fcs_idx_nx_s = 2'd0;
                end else begin
                    fcs_idx_nx_s = fcs_idx_r + 2'd1;
                end
            end
`endif
            ST_DRAIN: begin
                if (bus.in_valid && bus.in_last) begin
                    state_nx_s   = ST_IFG;
                    ifg_cnt_nx_s = {IFG_W{1'b0}};
                end else begin
                    state_nx_s   = ST_DRAIN;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_r == IFG_LAST) begin
                    state_nx_s   = ST_IDLE;
                    ifg_cnt_nx_s = {IFG_W{1'b0}};
                end else begin
                    ifg_cnt_nx_s = ifg_cnt_r + {{(IFG_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, CRC and output registers with synchronous reset.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_r    <= ST_IDLE;
            pre_cnt_r  <= 3'd0;
            ifg_cnt_r  <= {IFG_W{1'b0}};
            tx_data_r  <= 8'h00;
            tx_en_r    <= 1'b0;
            tx_er_r    <= 1'b0;
            busy_r     <= 1'b0;
            underrun_r <= 1'b0;
`ifdef GMII_TX_FCS_EN
            byte_cnt_r <= 11'd0;
            crc_r      <= CRC32_INIT;
            fcs_idx_r  <= 2'd0;
`endif
        end else begin
            state_r    <= state_nx_s;
            pre_cnt_r  <= pre_cnt_nx_s;
            ifg_cnt_r  <= ifg_cnt_nx_s;
            tx_data_r  <= tx_data_nx_s;
            tx_en_r    <= tx_en_nx_s;
            tx_er_r    <= tx_er_nx_s;
            busy_r     <= (state_nx_s != ST_IDLE);
            underrun_r <= underrun_nx_s;
`ifdef GMII_TX_FCS_EN
            byte_cnt_r <= byte_cnt_nx_s;
            crc_r      <= crc_nx_s;
            fcs_idx_r  <= fcs_idx_nx_s;
`endif
        end
    end

    assign bus.in_ready = (state_r == ST_DATA) || (state_r == ST_DRAIN);
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_en    = tx_en_r;
    assign bus.tx_er    = tx_er_r;
    assign bus.busy     = busy_r;
    assign bus.underrun = underrun_r;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: directed scenarios with random payloads
// compared against a frame-level reference model (preamble, payload, pad, FCS, gaps).
module tb_gmii_tx_framer;

    localparam int IFG  = 12;
    localparam int MINP = 60;

    logic tx_clk = 1'b0;
    logic tx_rst = 1'b1;

    gmii_tx_framer_if bus ();

    gmii_tx_framer #(.IFG_CYCLES(IFG), .MIN_PAYLOAD(MINP)) dut (
        .tx_clk (tx_clk),
        .tx_rst (tx_rst),
        .bus    (bus)
    );

    logic [31:0] u_ci;
    logic [31:0] u_co;
    logic [7:0]  u_d;

    crc32_d8 u_crc (
        .crc_in  (u_ci),
        .data    (u_d),
        .crc_out (u_co)
    );

    always #4 tx_clk = ~tx_clk;

    int checks   = 0;
    int failures = 0;

    bit         logging = 1'b0;
    logic [7:0] lg_d[$];
    logic       lg_en[$], lg_er[$], lg_und[$], lg_v[$], lg_rdy[$];

    logic [7:0] ex_d[$];
    logic       ex_er[$];
    int         ex_len[$];

    logic [7:0] s_d[$];
    logic       s_l[$], s_e[$];

    // Output monitor, sampled away from the active edge.
    always @(negedge tx_clk) begin
        if (logging) begin
            lg_d.push_back(bus.tx_data);
            lg_en.push_back(bus.tx_en);
            lg_er.push_back(bus.tx_er);
            lg_und.push_back(bus.underrun);
            lg_v.push_back(bus.in_valid);
            lg_rdy.push_back(bus.in_ready);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef GMII_TX_FCS_EN
    // Bit-serial CRC-32 (LSB first), returns the value as transmitted.
    function automatic logic [31:0] fcs_of(input logic [7:0] msg[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (msg[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ msg[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction
`endif

    task automatic push_exp(input logic [7:0] d, input logic e);
        ex_d.push_back(d);
        ex_er.push_back(e);
    endtask

    task automatic model_frame(input logic [7:0] pl[$], input logic pe[$]);
        int n0;
`ifdef GMII_TX_FCS_EN
        logic [7:0]  body[$];
        logic [31:0] f;
`endif
        n0 = ex_d.size();
        repeat (7) push_exp(8'h55, 1'b0);
        push_exp(8'hD5, 1'b0);
        foreach (pl[i]) push_exp(pl[i], pe[i]);
`ifdef GMII_TX_FCS_EN
        body = pl;
        while (body.size() < MINP) begin
            body.push_back(8'h00);
            push_exp(8'h00, 1'b0);
        end
        f = fcs_of(body);
        for (int k = 0; k < 4; k++) push_exp(f[8*k +: 8], 1'b0);
`endif
        ex_len.push_back(ex_d.size() - n0);
    endtask

    // Truncated frame: header, first n stream bytes, then the errored 0x00 byte.
    task automatic model_underrun(input int n);
        repeat (7) push_exp(8'h55, 1'b0);
        push_exp(8'hD5, 1'b0);
        for (int i = 0; i < n; i++) push_exp(s_d[i], s_e[i]);
        push_exp(8'h00, 1'b1);
        ex_len.push_back(n + 9);
    endtask

    task automatic add_frame(input int len, input bit rnd, input bit mdl);
        logic [7:0] pl[$];
        logic       pe[$];
        logic [7:0] b;
        logic       e;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            e = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            pl.push_back(b);
            pe.push_back(e);
            s_d.push_back(b);
            s_l.push_back(i == len - 1);
            s_e.push_back(e);
        end
        if (mdl) model_frame(pl, pe);
    endtask

    task automatic drive_stream(input int drop_at);
        int i;
        int guard;
        bit acc;
        bit dropped;
        i = 0; guard = 0; dropped = 1'b0;
        @(posedge tx_clk); #1;
        while (i < s_d.size() && guard < 20000) begin
            if (i == drop_at && !dropped) begin
                dropped      = 1'b1;
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                repeat (2) begin
                    @(posedge tx_clk); #1;
                end
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = s_d[i];
                bus.in_last  = s_l[i];
                bus.in_err   = s_e[i];
                @(negedge tx_clk);
                acc = bus.in_ready;
                @(posedge tx_clk); #1;
                if (acc) i++;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_err   = 1'b0;
        bus.in_data  = 8'h00;
        chk("drive_done", i, s_d.size());
        s_d.delete(); s_l.delete(); s_e.delete();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge tx_clk);
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", bus.busy, 1'b0);
        repeat (3) @(negedge tx_clk);
    endtask

    task automatic check_log(input bit gaps, input int exp_und);
        int i, start, len, f, pos, prev_end, und, n;
        i = 0; f = 0; pos = 0; prev_end = -1; und = 0;
        n = lg_en.size();
        foreach (lg_und[k]) if (lg_und[k] === 1'b1) und++;
        while (i < n) begin
            if (lg_en[i] === 1'b1) begin
                start = i;
                while (i < n && lg_en[i] === 1'b1) i++;
                len = i - start;
                if (gaps && prev_end >= 0) chk("ifg_gap", start - prev_end, IFG);
                prev_end = i;
                if (f < ex_len.size()) begin
                    chk("frame_len", len, ex_len[f]);
                    for (int j = 0; j < len && j < ex_len[f]; j++) begin
                        chk("frame_data", lg_d[start + j], ex_d[pos + j]);
                        chk("frame_er", lg_er[start + j], ex_er[pos + j]);
                    end
                    pos += ex_len[f];
                end
                f++;
            end else begin
                i++;
            end
        end
        chk("frame_count", f, ex_len.size());
        chk("underrun_count", und, exp_und);
        lg_d.delete(); lg_en.delete(); lg_er.delete(); lg_und.delete();
        lg_v.delete(); lg_rdy.delete();
        ex_d.delete(); ex_er.delete(); ex_len.delete();
    endtask

    task automatic watch_rst(input int target, input logic [7:0] exp_byte);
        int en_cnt;
        en_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge tx_clk);
            if (bus.tx_en === 1'b1) en_cnt++;
            if (en_cnt == target) break;
        end
        chk("rst_watch_hit", en_cnt, target);
        chk("byte_before_rst", bus.tx_data, exp_byte);
        tx_rst = 1'b1;
        @(negedge tx_clk);
        chk("rst_tx_en", bus.tx_en, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        @(posedge tx_clk); #1;
        tx_rst = 1'b0;
    endtask

    initial begin
        int          v0, en0, rdy0, uk;
        logic [7:0]  rst_byte;
`ifdef GMII_TX_FCS_EN
        logic [7:0]  ramp[$];
        logic [31:0] ramp_fcs;
`endif
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_err   = 1'b0;
        u_ci = 32'h00000000;
        u_d  = 8'h00;

        repeat (3) @(negedge tx_clk);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_tx_en0", bus.tx_en, 1'b0);
        chk("rst_tx_er", bus.tx_er, 1'b0);
        chk("rst_busy0", bus.busy, 1'b0);
        chk("rst_underrun", bus.underrun, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        @(posedge tx_clk); #1;
        tx_rst = 1'b0;

        // CRC helper on the standard check string "123456789".
        u_ci = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) begin
            u_d = 8'(32'h31 + i);
            #1;
            u_ci = u_co;
        end
        chk("crc32_check", ~u_ci, 32'hCBF43926);

        // 64-byte ramp payload with start-of-frame timing.
        logging = 1'b1;
        add_frame(64, 1'b0, 1'b1);
        drive_stream(-1);
        wait_idle();
        logging = 1'b0;
        v0 = -1; en0 = -1; rdy0 = -1;
        foreach (lg_v[k]) if (v0 < 0 && lg_v[k] === 1'b1) v0 = k;
        foreach (lg_en[k]) if (en0 < 0 && lg_en[k] === 1'b1) en0 = k;
        foreach (lg_rdy[k]) if (rdy0 < 0 && lg_rdy[k] === 1'b1) rdy0 = k;
        chk("en_latency", en0 - v0, 1);
        chk("rdy_latency", rdy0 - v0, 8);
        chk("sfd_cycle8", (v0 >= 0 && v0 + 8 < lg_d.size()) ? lg_d[v0 + 8] : 8'hxx, 8'hD5);
        check_log(1'b0, 0);

        // Short payload (padding when FCS is built in).
        logging = 1'b1;
        add_frame(10, 1'b1, 1'b1);
        drive_stream(-1);
        wait_idle();
        logging = 1'b0;
        check_log(1'b0, 0);

        // Back-to-back frames around the minimum-length boundary, in_valid held high.
        logging = 1'b1;
        add_frame(59, 1'b1, 1'b1);
        add_frame(60, 1'b1, 1'b1);
        add_frame(1, 1'b1, 1'b1);
        add_frame($urandom_range(61, 120), 1'b1, 1'b1);
        drive_stream(-1);
        wait_idle();
        logging = 1'b0;
        check_log(1'b1, 0);

        // Underrun after payload byte 20, followed by a normal frame.
        logging = 1'b1;
        add_frame(40, 1'b1, 1'b0);
        model_underrun(20);
        add_frame(30, 1'b1, 1'b1);
        drive_stream(20);
        wait_idle();
        logging = 1'b0;
        uk = -1;
        foreach (lg_und[k]) if (uk < 0 && lg_und[k] === 1'b1) uk = k;
        chk("underrun_err_byte", (uk >= 0) ? {lg_en[uk], lg_er[uk], lg_d[uk]} : 10'h000, 10'h300);
        check_log(1'b0, 1);

        // Reset late in a frame, then a clean frame.
`ifdef GMII_TX_FCS_EN
        for (int i = 0; i < 64; i++) ramp.push_back(8'(i));
        ramp_fcs = fcs_of(ramp);
        rst_byte = ramp_fcs[15:8];
`else
        rst_byte = 8'd63;
`endif
        add_frame(64, 1'b0, 1'b0);
        fork
            drive_stream(-1);
`ifdef GMII_TX_FCS_EN
            watch_rst(8 + 64 + 2, rst_byte);
`else
            watch_rst(8 + 64, rst_byte);
`endif
        join
        repeat (2) @(negedge tx_clk);
        logging = 1'b1;
        add_frame(64, 1'b1, 1'b1);
        drive_stream(-1);
        wait_idle();
        logging = 1'b0;
        check_log(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
